// File: rtl/riscv_pkg.sv
// Shared decode constants and types for the RV64 single-cycle controller.
package riscv_pkg;

  // Major opcodes handled by the controller
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // funct3 encodings
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_SD  = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SUB = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;

  // funct7 encodings
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // ALU operation as driven on ALUControl
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_ctrl_e;

  // Immediate format selected by the main decoder
  typedef enum logic [1:0] {
    IMM_NONE = 2'b00,
    IMM_I    = 2'b01,
    IMM_S    = 2'b10,
    IMM_B    = 2'b11
  } imm_sel_e;

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational immediate generator: I, S and B formats, sign-extended to XLEN.
module riscv_imm_gen #(
  parameter int unsigned XLEN = 64
) (
  input  logic [0:31]              Instruction,
  input  riscv_pkg::imm_sel_e      imm_sel,
  output logic [XLEN-1:0]          imm
);
  import riscv_pkg::*;

  // Packed-to-packed copy keeps MSB-first order, so instr[31] is Instruction[0]
  logic [31:0] instr;
  assign instr = Instruction;

  // Opcode and funct3/rs1 bits never feed an immediate
  logic unused_fields;
  assign unused_fields = ^{instr[19:12], instr[6:0]};

  // Assemble the selected format and replicate its MSB up to XLEN-1
  always_comb begin
    imm = '0;
    unique case (imm_sel)
      IMM_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/riscv_controller.sv
// Main decoder for the RV64 single-cycle core; all outputs registered (1-cycle latency).
module riscv_controller #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [0:31]     Instruction,
  output logic [1:0]      ALUControl,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            Branch,
  output logic            MemToReg,
  output logic            ALUScr,
  output logic [0:XLEN-1] Imm
);
  import riscv_pkg::*;

  logic [31:0] instr;
  assign instr = Instruction;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register specifiers are not needed for control decode
  logic unused_fields;
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  alu_ctrl_e       alu_r;
  logic            r_legal;
  alu_ctrl_e       alu_next;
  logic            reg_write_next;
  logic            mem_write_next;
  logic            branch_next;
  logic            mem_to_reg_next;
  logic            alu_src_next;
  imm_sel_e        imm_sel;
  logic [XLEN-1:0] imm_next;

  // ALU decode of R-type funct7/funct3; flags combinations outside the supported set
  always_comb begin
    alu_r   = ALU_ADD;
    r_legal = 1'b0;
    unique case ({funct7, funct3})
      {F7_BASE, F3_ADD}: begin alu_r = ALU_ADD; r_legal = 1'b1; end
      {F7_SUB,  F3_SUB}: begin alu_r = ALU_SUB; r_legal = 1'b1; end
      {F7_BASE, F3_AND}: begin alu_r = ALU_AND; r_legal = 1'b1; end
      {F7_BASE, F3_OR }: begin alu_r = ALU_OR;  r_legal = 1'b1; end
      default: begin alu_r = ALU_ADD; r_legal = 1'b0; end
    endcase
  end

  // Main decode; anything unrecognised falls through to the all-zero NOP defaults
  always_comb begin
    alu_next        = ALU_ADD;
    reg_write_next  = 1'b0;
    mem_write_next  = 1'b0;
    branch_next     = 1'b0;
    mem_to_reg_next = 1'b0;
    alu_src_next    = 1'b0;
    imm_sel         = IMM_NONE;
    case (opcode)
      OP_LOAD: begin
        if (funct3 == F3_LD) begin
          reg_write_next  = 1'b1;
          mem_to_reg_next = 1'b1;
          alu_src_next    = 1'b1;
          imm_sel         = IMM_I;
        end
      end
      OP_STORE: begin
        if (funct3 == F3_SD) begin
          mem_write_next = 1'b1;
          alu_src_next   = 1'b1;
          imm_sel        = IMM_S;
        end
      end
      OP_RTYPE: begin
        if (r_legal) begin
          reg_write_next = 1'b1;
          alu_next       = alu_r;
        end
      end
      OP_BRANCH: begin
        if (funct3 == F3_BEQ) begin
          branch_next = 1'b1;
          alu_next    = ALU_SUB;
          imm_sel     = IMM_B;
        end
      end
      default: ;
    endcase
  end

  riscv_imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .Instruction(Instruction),
    .imm_sel    (imm_sel),
    .imm        (imm_next)
  );

  // Output register stage; reset discards the decode result of that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      ALUControl <= '0;
      RegWrite   <= 1'b0;
      MemWrite   <= 1'b0;
      Branch     <= 1'b0;
      MemToReg   <= 1'b0;
      ALUScr     <= 1'b0;
      Imm        <= '0;
    end else begin
      ALUControl <= alu_next;
      RegWrite   <= reg_write_next;
      MemWrite   <= mem_write_next;
      Branch     <= branch_next;
      MemToReg   <= mem_to_reg_next;
      ALUScr     <= alu_src_next;
      Imm        <= imm_next;
    end
  end

endmodule

// File: tb/tb_riscv_controller.sv
// Directed self-checking bench for riscv_controller.
module tb_riscv_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:31] Instruction;
  logic [1:0]  ALUControl;
  logic        RegWrite;
  logic        MemWrite;
  logic        Branch;
  logic        MemToReg;
  logic        ALUScr;
  logic [0:63] Imm;

  int unsigned passed = 0;
  int unsigned total  = 0;

  riscv_controller #(.XLEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .Instruction(Instruction),
    .ALUControl (ALUControl),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .Branch     (Branch),
    .MemToReg   (MemToReg),
    .ALUScr     (ALUScr),
    .Imm        (Imm)
  );

  always #5 clk = ~clk;

  // Observed outputs as one vector: {ALUControl, RegWrite, MemWrite, Branch, MemToReg, ALUScr, Imm}
  logic [70:0] obs;
  assign obs = {ALUControl, RegWrite, MemWrite, Branch, MemToReg, ALUScr, Imm};

  // Builds an expected vector in the same field order as obs
  function automatic logic [70:0] ctl(input logic [1:0] alu, input logic rw, input logic mw,
                                      input logic br, input logic m2r, input logic src,
                                      input logic [63:0] imm);
    return {alu, rw, mw, br, m2r, src, imm};
  endfunction

  localparam logic [70:0] ZERO = '0;

  localparam logic [31:0] I_LD     = 32'h36A33503;
  localparam logic [31:0] I_LD_NEG = 32'hFFF33503;
  localparam logic [31:0] I_SD     = 32'h36A33523;
  localparam logic [31:0] I_ADD    = 32'h00A30533;
  localparam logic [31:0] I_SUB    = 32'h40A30533;
  localparam logic [31:0] I_AND    = 32'h00A37533;
  localparam logic [31:0] I_OR     = 32'h00A36533;
  localparam logic [31:0] I_BEQ    = 32'h14A30563;
  localparam logic [31:0] I_BEQ_M2 = 32'hFE000FE3;
  localparam logic [31:0] I_BEQ_MX = 32'h80000063;
  localparam logic [31:0] I_ADDI   = 32'h00A30513;
  localparam logic [31:0] I_RF7    = 32'h02A30533;
  localparam logic [31:0] I_LW     = 32'h36A32503;

  // Drive a new instruction at the falling edge, then sample 1 time unit after the rising edge
  task automatic apply(input logic [31:0] ins, input logic r);
    @(negedge clk);
    Instruction = ins;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [70:0] e_ld;
    e_ld = ctl(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'd874);
    for (int i = 0; i < 2; i++) begin
      apply(I_LD, 1'b1);
      total++;
      if (obs !== ZERO) $display("FAIL reset_hold%0d got %h exp %h", i, obs, ZERO);
      else passed++;
    end
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (obs !== ZERO) $display("FAIL reset_release_pre got %h exp %h", obs, ZERO);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (obs !== e_ld) $display("FAIL reset_release_post got %h exp %h", obs, e_ld);
    else passed++;
  endtask

  task automatic test_load;
    logic [70:0] e;
    apply(I_LD, 1'b0);
    e = ctl(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'd874);
    total++;
    if (obs !== e) $display("FAIL ld_874 got %h exp %h", obs, e);
    else passed++;
    apply(I_LD_NEG, 1'b0);
    e = ctl(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    total++;
    if (obs !== e) $display("FAIL ld_neg1 got %h exp %h", obs, e);
    else passed++;
  endtask

  task automatic test_store;
    logic [70:0] e;
    apply(I_SD, 1'b0);
    e = ctl(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'd874);
    total++;
    if (obs !== e) $display("FAIL sd_874 got %h exp %h", obs, e);
    else passed++;
  endtask

  // Back-to-back R-types: outputs hold the previous op until the edge, then switch
  task automatic test_rtype;
    logic [31:0] ins [4];
    logic [1:0]  alu [4];
    logic [70:0] prev;
    logic [70:0] e;
    ins = '{I_ADD, I_SUB, I_AND, I_OR};
    alu = '{2'b00, 2'b01, 2'b10, 2'b11};
    prev = ctl(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'd874);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      Instruction = ins[i];
      rst = 1'b0;
      #1;
      total++;
      if (obs !== prev) $display("FAIL rtype%0d_pre got %h exp %h", i, obs, prev);
      else passed++;
      @(posedge clk);
      #1;
      e = ctl(alu[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
      total++;
      if (obs !== e) $display("FAIL rtype%0d_post got %h exp %h", i, obs, e);
      else passed++;
      prev = e;
    end
  endtask

  task automatic test_branch;
    logic [70:0] e;
    apply(I_BEQ, 1'b0);
    e = ctl(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd330);
    total++;
    if (obs !== e) $display("FAIL beq_330 got %h exp %h", obs, e);
    else passed++;
    apply(I_BEQ_M2, 1'b0);
    e = ctl(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
    total++;
    if (obs !== e) $display("FAIL beq_neg2 got %h exp %h", obs, e);
    else passed++;
    apply(I_BEQ_MX, 1'b0);
    e = ctl(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_F000);
    total++;
    if (obs !== e) $display("FAIL beq_neg4096 got %h exp %h", obs, e);
    else passed++;
  endtask

  task automatic test_illegal;
    logic [31:0] ins [3];
    ins = '{I_ADDI, I_RF7, I_LW};
    for (int i = 0; i < 3; i++) begin
      apply(ins[i], 1'b0);
      total++;
      if (obs !== ZERO) $display("FAIL illegal%0d got %h exp %h", i, obs, ZERO);
      else passed++;
    end
  endtask

  // Same instruction held for several cycles stays stable
  task automatic test_hold;
    logic [70:0] e;
    e = ctl(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    for (int i = 0; i < 3; i++) begin
      apply(I_OR, 1'b0);
      total++;
      if (obs !== e) $display("FAIL hold%0d got %h exp %h", i, obs, e);
      else passed++;
    end
  endtask

  task automatic test_reset_midstream;
    logic [70:0] e_ld;
    e_ld = ctl(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'd874);
    apply(I_LD, 1'b0);
    total++;
    if (obs !== e_ld) $display("FAIL mid_ld got %h exp %h", obs, e_ld);
    else passed++;
    apply(I_LD, 1'b1);
    total++;
    if (obs !== ZERO) $display("FAIL mid_rst got %h exp %h", obs, ZERO);
    else passed++;
    apply(I_LD, 1'b0);
    total++;
    if (obs !== e_ld) $display("FAIL mid_recover got %h exp %h", obs, e_ld);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    Instruction = '0;
    test_reset;
    test_load;
    test_store;
    test_rtype;
    test_branch;
    test_illegal;
    test_hold;
    test_reset_midstream;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
